// File: rtl/full_adder_pkg.sv
// Shared constants and the arithmetic reference for the full_adder block.
package full_adder_pkg;

  localparam int FA_MAX_WIDTH = 64;

  // Exact unsigned sum x + y + c_in, one bit wider than the operands.
  function automatic logic [FA_MAX_WIDTH:0] fa_ref(
    input logic [FA_MAX_WIDTH-1:0] x,
    input logic [FA_MAX_WIDTH-1:0] y,
    input logic                    c_in
  );
    return {1'b0, x} + {1'b0, y} + {{FA_MAX_WIDTH{1'b0}}, c_in};
  endfunction

endpackage

// File: rtl/full_adder_cell.sv
// Combinational 1-bit full-adder cell; the leaf of the ripple-carry chain.
module full_adder_cell (
  input  logic a,
  input  logic b,
  input  logic ci,
  output logic sum,
  output logic co
);

  assign sum = a ^ b ^ ci;
  assign co  = (a & b) | (ci & (a ^ b));

endmodule

// File: rtl/full_adder.sv
// Registered ripple-carry adder: {c_out, s} = x + y + c_in with one cycle of
// latency and a valid flag. Optional macro FULL_ADDER_OVF_EN adds a registered
// two's-complement overflow output ovf.
module full_adder
  import full_adder_pkg::*;
#(
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] x,
  input  logic [WIDTH-1:0] y,
  input  logic             c_in,
  output logic             out_valid,
  output logic [WIDTH-1:0] s,
  output logic             c_out
`ifdef FULL_ADDER_OVF_EN
  ,
  output logic             ovf
`endif
);

  if (WIDTH < 1 || WIDTH > FA_MAX_WIDTH) begin : g_bad_width
    $error("full_adder: WIDTH out of range 1..%0d", FA_MAX_WIDTH);
  end

  // ---- stage p0: combinational carry chain from the input ports ----
  logic [WIDTH:0]   carry_p0;
  logic [WIDTH-1:0] sum_p0;

  assign carry_p0[0] = c_in;

  for (genvar i = 0; i < WIDTH; i++) begin : g_cell
    full_adder_cell u_cell (
      .a   (x[i]),
      .b   (y[i]),
      .ci  (carry_p0[i]),
      .sum (sum_p0[i]),
      .co  (carry_p0[i+1])
    );
  end

  // ---- stage p1: output registers ----

  // Valid flag follows in_valid by one cycle; a reset discards anything in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) out_valid <= 1'b0;
    else        out_valid <= in_valid;
  end

  // Result registers load only on a valid input, so idle inputs cannot disturb them.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s     <= '0;
      c_out <= 1'b0;
    end else if (in_valid) begin
      s     <= sum_p0;
      c_out <= carry_p0[WIDTH];
    end
  end

`ifdef FULL_ADDER_OVF_EN
  // Signed overflow: carry into the sign bit differs from carry out of it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)        ovf <= 1'b0;
    else if (in_valid) ovf <= carry_p0[WIDTH] ^ carry_p0[WIDTH-1];
  end
`endif

endmodule

// File: tb/tb_full_adder.sv
// Scoreboard bench for full_adder: a WIDTH=1 and a WIDTH=8 instance share a
// clock and reset; expected results are queued at the sampling edge and
// popped by a monitor on the falling edge.
module tb_full_adder;
  import full_adder_pkg::*;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  logic       iv1 = 0, x1 = 0, y1 = 0, ci1 = 0;
  logic       ov1, s1, co1;
  logic       iv8 = 0, ci8 = 0;
  logic [7:0] x8 = 0, y8 = 0, s8;
  logic       ov8, co8;
`ifdef FULL_ADDER_OVF_EN
  logic       f1, f8;
`endif

  full_adder #(.WIDTH(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv1), .x(x1), .y(y1), .c_in(ci1),
    .out_valid(ov1), .s(s1), .c_out(co1)
`ifdef FULL_ADDER_OVF_EN
    , .ovf(f1)
`endif
  );

  full_adder #(.WIDTH(8)) dut8 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv8), .x(x8), .y(y8), .c_in(ci8),
    .out_valid(ov8), .s(s8), .c_out(co8)
`ifdef FULL_ADDER_OVF_EN
    , .ovf(f8)
`endif
  );

  typedef struct packed {
    logic [8:0] res;
    logic       ovf;
  } exp_t;

  exp_t q1[$];
  exp_t q8[$];
  exp_t hold1 = '0;
  exp_t hold8 = '0;
  int   n_cmp = 0;
  int   n_err = 0;

  // Reference: unsigned sum from plain arithmetic, overflow from signed range.
  function automatic exp_t model(input int w, input logic [7:0] a,
                                 input logic [7:0] b, input logic c);
    exp_t e;
    logic [FA_MAX_WIDTH:0] r;
    logic [7:0] m;
    int sa, sb, ss, lim;
    m = 8'((1 << w) - 1);
    r = fa_ref(64'(a & m), 64'(b & m), c);
    e.res = r[8:0];
    lim = 1 << (w - 1);
    sa = int'(a & m); if (sa >= lim) sa = sa - 2 * lim;
    sb = int'(b & m); if (sb >= lim) sb = sb - 2 * lim;
    ss = sa + sb + int'(c);
    e.ovf = (ss >= lim) || (ss < -lim);
    return e;
  endfunction

  // Queue what each DUT should present after this edge.
  always @(posedge clk) begin
    if (rst_n) begin
      if (iv1) q1.push_back(model(1, {7'd0, x1}, {7'd0, y1}, ci1));
      if (iv8) q8.push_back(model(8, x8, y8, ci8));
    end
  end

  // A reset drops everything in flight and clears the held values.
  always @(negedge rst_n) begin
    q1.delete();
    q8.delete();
    hold1 = '0;
    hold8 = '0;
  end

  // Monitor: valid results are popped, idle cycles must show the held value.
  always @(negedge clk) begin
    exp_t e;
    n_cmp++;
    if (ov1 && q1.size() == 0) begin
      n_err++; $display("FAIL w1_stale: out_valid=1 with nothing expected");
    end else if (!ov1 && q1.size() != 0) begin
      n_err++; $display("FAIL w1_missing: out_valid=0, expected res=%b", q1[0].res[1:0]);
      void'(q1.pop_front());
    end else begin
      if (ov1) begin e = q1.pop_front(); hold1 = e; end
      if ({co1, s1} != hold1.res[1:0]) begin
        n_err++; $display("FAIL w1_result: got {c_out,s}=%b want %b (valid=%b)",
                          {co1, s1}, hold1.res[1:0], ov1);
      end
`ifdef FULL_ADDER_OVF_EN
      if (f1 != hold1.ovf) begin
        n_err++; $display("FAIL w1_ovf: got %b want %b", f1, hold1.ovf);
      end
`endif
    end

    n_cmp++;
    if (ov8 && q8.size() == 0) begin
      n_err++; $display("FAIL w8_stale: out_valid=1 with nothing expected");
    end else if (!ov8 && q8.size() != 0) begin
      n_err++; $display("FAIL w8_missing: out_valid=0, expected res=%h", q8[0].res);
      void'(q8.pop_front());
    end else begin
      if (ov8) begin e = q8.pop_front(); hold8 = e; end
      if ({co8, s8} != hold8.res) begin
        n_err++; $display("FAIL w8_result: got {c_out,s}=%h want %h (valid=%b)",
                          {co8, s8}, hold8.res, ov8);
      end
`ifdef FULL_ADDER_OVF_EN
      if (f8 != hold8.ovf) begin
        n_err++; $display("FAIL w8_ovf: got %b want %b", f8, hold8.ovf);
      end
`endif
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set8(input logic v, input logic [7:0] a, input logic [7:0] b,
                      input logic c);
    iv8 = v; x8 = a; y8 = b; ci8 = c;
  endtask

  initial begin
    logic [2:0] v;
    // Reset with valid operands present: outputs must stay clear.
    #1 rst_n = 1'b0;
    iv1 = 1; x1 = 1; y1 = 1; ci1 = 1;
    set8(1, 8'hFF, 8'hFF, 1'b1);
    repeat (3) tick();
    rst_n = 1'b1;
    tick();

    // WIDTH=1 exhaustive truth table, back to back.
    iv8 = 0;
    for (int i = 0; i < 8; i++) begin
      v = 3'(i);
      iv1 = 1; x1 = v[2]; y1 = v[1]; ci1 = v[0];
      tick();
    end

    // Hold: idle inputs change but outputs keep the last result.
    iv1 = 1; x1 = 1; y1 = 0; ci1 = 0;
    tick();
    iv1 = 0; x1 = 1; y1 = 1; ci1 = 1;
    repeat (2) tick();

    // WIDTH=8 boundaries and overflow cases.
    set8(1, 8'hFF, 8'h00, 1'b1); tick();
    set8(1, 8'hFF, 8'hFF, 1'b1); tick();
    set8(1, 8'h00, 8'h00, 1'b0); tick();
    set8(1, 8'h7F, 8'h01, 1'b0); tick();
    set8(1, 8'h80, 8'hFF, 1'b0); tick();
    set8(1, 8'h01, 8'h01, 1'b0); tick();
    set8(0, 8'h55, 8'hAA, 1'b1); repeat (2) tick();

    // Randomized traffic on both instances.
    for (int i = 0; i < 300; i++) begin
      iv1 = 1'($urandom_range(0, 3) != 0);
      x1 = 1'($urandom); y1 = 1'($urandom); ci1 = 1'($urandom);
      set8(1'($urandom_range(0, 3) != 0), 8'($urandom), 8'($urandom), 1'($urandom));
      tick();
    end

    // Async reset between edges during back-to-back adds.
    iv1 = 1; x1 = 1; y1 = 1; ci1 = 0;
    set8(1, 8'hC3, 8'h5A, 1'b1);
    repeat (3) tick();
    #2 rst_n = 1'b0;
    #1;
    n_cmp++;
    if ({ov1, co1, s1} != 3'b000 || {ov8, co8, s8} != 10'h000) begin
      n_err++; $display("FAIL async_clear: w1=%b w8=%h want all zero",
                        {ov1, co1, s1}, {ov8, co8, s8});
    end
    repeat (2) tick();
    iv1 = 0; iv8 = 0;
    rst_n = 1'b1;
    repeat (2) tick();
    for (int i = 0; i < 20; i++) begin
      iv1 = 1; x1 = 1'($urandom); y1 = 1'($urandom); ci1 = 1'($urandom);
      set8(1, 8'($urandom), 8'($urandom), 1'($urandom));
      tick();
    end
    iv1 = 0; iv8 = 0;
    repeat (3) tick();

    n_cmp++;
    if (q1.size() != 0 || q8.size() != 0) begin
      n_err++; $display("FAIL drain: %0d/%0d results never presented", q1.size(), q8.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/full_adder.md
Name: full_adder

Overview:
Registered ripple-carry adder built from 1-bit full-adder cells. Computes {c_out, s} = x + y + c_in for WIDTH-bit operands. Outputs are registered with one cycle of latency and a valid flag. The default WIDTH=1 gives a clocked single-bit full adder, used as a leaf arithmetic block in datapaths.

Parameters:
WIDTH, 1, operand and sum width in bits; legal range 1..64.

Ports:
clk  input  1  rising-edge clock
rst_n  input  1  asynchronous active-low reset
in_valid  input  1  operands valid this cycle; sampled on the rising edge of clk
x  input  WIDTH  addend A, unsigned
y  input  WIDTH  addend B, unsigned
c_in  input  1  carry into bit 0
out_valid  output  1  s/c_out hold a fresh result
s  output  WIDTH  registered sum bits
c_out  output  1  registered carry out of bit WIDTH-1

Behaviour:
- Cell equations per bit i: s[i] = x[i]^y[i]^carry[i]; carry[i+1] = (x[i]&y[i]) | (carry[i]&(x[i]^y[i])). carry[0] = c_in. c_out = carry[WIDTH].
- Arithmetic result is exactly {c_out, s} = x + y + c_in, width WIDTH+1. There is no truncation or saturation.
- Reset: while rst_n=0, asynchronously force s=0, c_out=0, out_valid=0. Deassertion takes effect at the next clk edge.
- Latency: 1 cycle. If in_valid=1 at edge N, then s, c_out and out_valid=1 are visible after edge N.
- If in_valid=0 at an edge, s and c_out hold their previous values and out_valid drops to 0.
- Back-to-back in_valid=1 gives one result per cycle. There is no backpressure and no ready signal.
- Boundary conditions:
  - all-ones + all-ones + 1 gives s = all-ones, c_out = 1.
  - 0 + 0 + 0 gives s = 0, c_out = 0.
  - all-ones + 0 + 1 carries through every bit, giving s = 0, c_out = 1.
- Reset asserted mid-stream drops any result in flight. The first out_valid after reset corresponds to the first in_valid sampled after reset release.
- X/Z on inputs while in_valid=0 must not disturb the held outputs.
- The carry chain is purely combinational between the input ports and the output registers; there are no internal pipeline stages.

Optional Feature:
FULL_ADDER_OVF_EN
- Defined: adds output port ovf (output, 1 bit) = carry[WIDTH] ^ carry[WIDTH-1].
  - This is the two's-complement signed overflow of the add.
  - Registered alongside s, reset to 0, and held when in_valid=0.
  - For WIDTH=1, carry[0] is c_in.
- Not defined: the ovf port and its register do not exist. All other behaviour is identical.

Decomposition:
- Package full_adder_pkg holds:
  - the constant FA_MAX_WIDTH = 64;
  - a function fa_ref(x, y, c_in) returning the WIDTH+1-bit sum, used by the verification scoreboard.
- One sub-module, full_adder_cell, is the combinational 1-bit cell with ports a, b, ci, sum, co.
  - full_adder instantiates WIDTH copies in a generate loop, chained through carry[].
  - The output registers, valid flag and optional ovf logic live in full_adder.

Test Plan:
- Reset check: hold rst_n=0 with in_valid=1, x=1, y=1, c_in=1 → s=0, c_out=0, out_valid=0 throughout. Deassert reset → the first valid result appears one cycle later as s=1, c_out=1.
- WIDTH=1 exhaustive truth table: apply {x,y,c_in} = 000, 001, 010, 011, 100, 101, 110, 111 on consecutive cycles with in_valid=1.
  - Required {c_out,s} one cycle later: 00, 01, 01, 10, 01, 10, 10, 11.
  - out_valid stays 1 for all eight cycles.
- Hold check: after x=1, y=0, c_in=0 (s=1, c_out=0), drive in_valid=0 and change the inputs to 1, 1, 1 → s=1 and c_out=0 are held, and out_valid=0.
- WIDTH=8 carry propagate: x=8'hFF, y=8'h00, c_in=1 → s=8'h00, c_out=1. Then x=8'hFF, y=8'hFF, c_in=1 → s=8'hFF, c_out=1.
- Async reset mid-stream: assert rst_n=0 between clock edges during back-to-back adds → outputs clear immediately, without waiting for a clock edge, and no stale out_valid pulse appears after release.
- With FULL_ADDER_OVF_EN at WIDTH=8:
  - 8'h7F + 8'h01 + 0 → s=8'h80, c_out=0, ovf=1.
  - 8'h80 + 8'hFF + 0 → s=8'h7F, c_out=1, ovf=1.
  - 8'h01 + 8'h01 + 0 → ovf=0.
